sd_reg_initiator: RTL and testbench

//  Bus initiator for the SD host register file's req/rw/addr/ack port.

---
 rtl/sd_reg_initiator.sv | 128 ++++++++++++
 tb/tb_sd_reg_initiator.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sd_reg_initiator.sv
// sd_reg_initiator: single-command req/ack bus initiator for the SD host
// register file. Accepts one read/write command at a time, runs one req/ack
// handshake and returns a one-cycle response pulse.
// Optional feature macro: SD_REG_INITIATOR_TIMEOUT_EN enables the WAIT_ACK
// timeout counter and the rsp_err timeout response; without it WAIT_ACK waits
// indefinitely and rsp_err is tied low.
module sd_reg_initiator #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned TO_W        = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              reg_req,
    output logic              reg_rw,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_data_in,
    input  logic [DATA_W-1:0] reg_data_out,
    input  logic              reg_ack
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_ACK = 2'd1;
    localparam logic [1:0] RELEASE  = 2'd2;

    logic [1:0] state;

    // An ack only counts once it has been seen low inside WAIT_ACK, so an ack
    // already high at accept time (stale or spurious) can never complete the
    // command. With the register file's timing the low sample always lands on
    // the first WAIT_ACK edge, so normal latency is unchanged.
    logic       ack_armed;

`ifdef SD_REG_INITIATOR_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] count;
    logic            err_q;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign cmd_ready = (state == IDLE) && !reset;
    assign busy      = (state != IDLE);

    // Command FSM: accept, hold req until a fresh ack, respond, wait for ack release.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ack_armed   <= 1'b0;
            reg_req     <= 1'b0;
            reg_rw      <= 1'b0;
            reg_addr    <= '0;
            reg_data_in <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
`ifdef SD_REG_INITIATOR_TIMEOUT_EN
            count       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    if (cmd_valid) begin
                        reg_rw      <= cmd_rw;
                        reg_addr    <= cmd_addr;
                        reg_data_in <= cmd_wdata;
                        reg_req     <= 1'b1;
                        ack_armed   <= 1'b0;
`ifdef SD_REG_INITIATOR_TIMEOUT_EN
                        count       <= '0;
`endif
                        state       <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
`ifdef SD_REG_INITIATOR_TIMEOUT_EN
                    count <= count + 1'b1;
`endif
                    if (!reg_ack) begin
                        ack_armed <= 1'b1;
                    end
                    if (reg_ack && ack_armed) begin
                        reg_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= reg_rw ? reg_data_out : '0;
`ifdef SD_REG_INITIATOR_TIMEOUT_EN
                        err_q     <= 1'b0;
`endif
                        state     <= RELEASE;
                    end
`ifdef SD_REG_INITIATOR_TIMEOUT_EN
                    else if (count == TO_LAST) begin
                        reg_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        err_q     <= 1'b1;
                        state     <= RELEASE;
                    end
`endif
                end
                RELEASE: begin
                    rsp_valid <= 1'b0;
                    if (!reg_ack) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    reg_req   <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_reg_initiator.sv
// Self-checking bench for sd_reg_initiator with a behavioural register file
// and a word-array reference model of expected responses.
module tb_sd_reg_initiator;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic [4:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        reg_req;
    logic        reg_rw;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data_in;
    logic [31:0] reg_data_out;
    logic        reg_ack;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sd_reg_initiator #(
        .DATA_W(32),
        .ADDR_W(5),
        .TIMEOUT_CYC(TO),
        .TO_W(5)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy),
        .reg_req(reg_req), .reg_rw(reg_rw), .reg_addr(reg_addr),
        .reg_data_in(reg_data_in), .reg_data_out(reg_data_out), .reg_ack(reg_ack)
    );

    // Register file: ack follows req one edge late; mode 1 ties ack low, mode 2 forces it high.
    logic [31:0] rf [32];
    logic        ack_q = 1'b0;
    int          ack_mode = 0;
    initial for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    always @(posedge clk) begin
        ack_q <= reg_req;
        if (reg_req === 1'b1 && reg_rw === 1'b0) rf[reg_addr] <= reg_data_in;
    end
    assign reg_ack      = (ack_mode == 1) ? 1'b0 : (ack_mode == 2) ? 1'b1 : ack_q;
    assign reg_data_out = reg_ack ? rf[reg_addr] : 32'hBAD0_BAD0;

    // Reference model: contents the register file should hold after completed commands.
    logic [31:0] mem [32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One command end to end; exp_lat = cycles accept->rsp, exp_total = cycles accept->idle.
    task automatic run_cmd(input logic rw, input logic [4:0] addr, input logic [31:0] data,
                           input int exp_lat, input logic exp_err, input int exp_total);
        int          n;
        int          req_cnt;
        int          w;
        logic        got;
        logic [31:0] exp_rdata;
        cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_wdata = data;
        w = 0;
        while (!cmd_ready && w < 50) begin tick(); w++; end
        chk("accept_wait", {63'd0, cmd_ready}, 64'd1);
        tick();
        cmd_valid = 1'b0; cmd_wdata = $urandom; cmd_addr = 5'($urandom);
        chk("busy_after_accept", {63'd0, busy}, 64'd1);
        chk("latched_addr", {59'd0, reg_addr}, {59'd0, addr});
        chk("latched_rw", {63'd0, reg_rw}, {63'd0, rw});
        chk("latched_wdata", {32'd0, reg_data_in}, {32'd0, data});
        exp_rdata = (exp_err || !rw) ? 32'h0 : mem[addr];
        if (!rw) mem[addr] = data;
        req_cnt = reg_req ? 1 : 0;
        n = 0; got = 1'b0;
        while (!got && n < exp_lat + 20) begin
            tick(); n++;
            if (rsp_valid) got = 1'b1;
            else if (reg_req) req_cnt++;
        end
        chk("rsp_seen", {63'd0, got}, 64'd1);
        chk("rsp_latency", 64'(n), 64'(exp_lat));
        chk("req_high_edges", 64'(req_cnt), 64'(exp_lat));
        chk("rsp_err", {63'd0, rsp_err}, {63'd0, exp_err});
        chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, exp_rdata});
        tick(); n++;
        chk("rsp_one_cycle", {63'd0, rsp_valid}, 64'd0);
        while (busy && n < exp_total + 20) begin tick(); n++; end
        chk("idle_latency", 64'(n), 64'(exp_total));
    endtask

    initial begin
        int          acc;
        int          rsps;
        int          cyc;
        int          acc_t [3];
        logic        fire;
        logic        rw;
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] bw [3];

        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        reset = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        repeat (3) tick();
        chk("ready_in_reset", {63'd0, cmd_ready}, 64'd0);
        chk("rst_req", {63'd0, reg_req}, 64'd0);
        chk("rst_rw", {63'd0, reg_rw}, 64'd0);
        chk("rst_addr", {59'd0, reg_addr}, 64'd0);
        chk("rst_wdata", {32'd0, reg_data_in}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        chk("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        reset = 1'b0;
        tick();
        chk("ready_after_reset", {63'd0, cmd_ready}, 64'd1);

        // Directed write, then write/read pair.
        run_cmd(1'b0, 5'h02, 32'hDEADBEEF, 2, 1'b0, 4);
        chk("rf_2_written", {32'd0, rf[2]}, 64'hDEADBEEF);
        run_cmd(1'b0, 5'h03, 32'h12345678, 2, 1'b0, 4);
        run_cmd(1'b1, 5'h03, 32'h0, 2, 1'b0, 4);

        // Three writes with cmd_valid held high throughout.
        for (int i = 0; i < 3; i++) bw[i] = $urandom;
        acc = 0; rsps = 0; cyc = 0;
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 5'd10; cmd_wdata = bw[0];
        for (int k = 0; k < 24; k++) begin
            fire = cmd_valid && cmd_ready;
            tick(); cyc++;
            if (fire) begin
                acc_t[acc] = cyc;
                mem[10 + acc] = bw[acc];
                acc++;
                if (acc == 3) cmd_valid = 1'b0;
                else begin cmd_addr = 5'(10 + acc); cmd_wdata = bw[acc]; end
            end
            if (rsp_valid) begin
                if (rsps < acc) chk("b2b_rsp_latency", 64'(cyc - acc_t[rsps]), 64'd2);
                else chk("b2b_rsp_without_cmd", 64'(rsps), 64'(acc));
                chk("b2b_rdata", {32'd0, rsp_rdata}, 64'd0);
                rsps++;
            end
        end
        chk("b2b_accepts", 64'(acc), 64'd3);
        chk("b2b_rsps", 64'(rsps), 64'd3);
        for (int i = 0; i < 3; i++) run_cmd(1'b1, 5'(10 + i), 32'h0, 2, 1'b0, 4);

`ifdef SD_REG_INITIATOR_TIMEOUT_EN
        // Ack tied low: timeout response.
        ack_mode = 1;
        run_cmd(1'b1, 5'h09, 32'h0, TO, 1'b1, TO + 1);
        ack_mode = 0;
        tick();
        chk("ready_after_timeout", {63'd0, cmd_ready}, 64'd1);
`endif

        // Reset while in WAIT_ACK aborts without a response.
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 5'h02;
        tick();
        cmd_valid = 1'b0;
        chk("abort_busy_before", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        tick();
        chk("abort_req", {63'd0, reg_req}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_rsp", {63'd0, rsp_valid}, 64'd0);
        reset = 1'b0;
        rsps = 0;
        repeat (4) begin tick(); if (rsp_valid) rsps++; end
        chk("abort_no_rsp_after", 64'(rsps), 64'd0);
        run_cmd(1'b1, 5'h02, 32'h0, 2, 1'b0, 4);

        // Ack held high in IDLE: only a fresh ack completes the read.
        ack_mode = 2;
        repeat (2) tick();
        chk("idle_ack_ignored", {63'd0, busy}, 64'd0);
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 5'h03;
        tick();
        cmd_valid = 1'b0;
        rsps = 0;
        repeat (2) begin tick(); if (rsp_valid) rsps++; end
        chk("stale_ack_no_rsp", 64'(rsps), 64'd0);
        ack_mode = 1;
        tick();
        chk("stale_ack_still_no_rsp", {63'd0, rsp_valid}, 64'd0);
        ack_mode = 0;
        tick();
        chk("fresh_ack_rsp", {63'd0, rsp_valid}, 64'd1);
        chk("fresh_ack_rdata", {32'd0, rsp_rdata}, {32'd0, mem[3]});
        ack_mode = 2;
        repeat (3) begin
            tick();
            chk("release_holds", {63'd0, busy}, 64'd1);
        end
        ack_mode = 0;
        tick();
        chk("release_exit", {63'd0, busy}, 64'd0);

        // Random commands against the reference model.
        for (int i = 0; i < 20; i++) begin
            rw = 1'($urandom);
            a  = 5'($urandom);
            d  = $urandom;
            run_cmd(rw, a, d, 2, 1'b0, 4);
        end
        for (int i = 0; i < 32; i++) begin
            if (rf[i] !== mem[i]) chk("rf_contents", {32'd0, rf[i]}, {32'd0, mem[i]});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
